dff_var_reg: RTL and testbench
==============================

DFF_VAR_REG -- requirements
Module: dff_var_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports named clk and reset.
REQ-002 Parameter WIDTH SHALL default to 64 and SHALL set the register width in bits.
REQ-003 Parameter RESET_VALUE SHALL default to all-zeros and SHALL be the WIDTH-bit value loaded into q on reset.
REQ-004 Port clk SHALL be an input, 1 bit wide: the rising-edge clock for all state.
REQ-005 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high clear of q to RESET_VALUE.
REQ-006 Port q SHALL be an output, WIDTH bits wide: the registered data output.
REQ-007 Port d SHALL be an input, WIDTH bits wide: the data sampled on each rising clk edge.
REQ-008 Positional port order SHALL be (q, d, clk, reset) so that ordered instantiation binds correctly.
REQ-009 An elaboration-time check SHALL reject WIDTH < 1.

Function
REQ-010 Each bit i of q SHALL be held by an independent single-bit flip-flop cell with its own asynchronous reset; bits SHALL NOT interact.
REQ-011 The single-bit cell SHALL be a positive-edge D flip-flop with q, d, clk and reset ports, and SHALL clear to its reset bit whenever reset = 1.
REQ-012 The register SHALL be built structurally from WIDTH copies of the cell using a generate loop.
REQ-013 The block SHALL also provide a reusable 2:1 mux primitive with ports (sel, in[1:0], out), where out = in[1] when sel = 1 and out = in[0] otherwise.
REQ-014 In the top level, each cell's d SHALL be driven through that mux with sel tied to 1, so that the d bit always loads; this keeps the structure consistent with the enable-capable register variant.
REQ-015 On each rising clk edge with reset = 0, q SHALL become the value of d sampled at that edge, giving a latency of exactly 1 cycle.
REQ-016 Between rising edges, q SHALL hold its value regardless of changes on d.
REQ-017 When reset rises, q SHALL go to RESET_VALUE immediately, without waiting for a clock edge.
REQ-018 While reset = 1, clock edges SHALL be ignored and q SHALL remain RESET_VALUE.
REQ-019 When reset falls, the first rising clk edge with reset = 0 SHALL load d.
REQ-020 If reset and a clk edge occur simultaneously, reset SHALL take priority and q SHALL equal RESET_VALUE.
REQ-021 The q value before the first reset SHALL be left unspecified; verification SHALL NOT check q before the first reset.
REQ-022 An X or Z on d SHALL propagate to the corresponding q bits only on a clock edge; reset SHALL always produce a known q.
REQ-023 The block SHALL contain no combinational path from d to q.
REQ-024 The block SHALL contain no latches.

Reset
REQ-025 The reset value of q SHALL be RESET_VALUE, which is 64'd0 at default parameters.
REQ-026 Reset SHALL be the only initialization mechanism; no initial blocks SHALL be used for state.
REQ-027 Reset assertion SHALL be asynchronous, and release SHALL be sampled at the next rising edge; no synchronizer SHALL be included inside the block.

Verification
REQ-028 Power-up reset: with d = X, assert reset = 1 for 1 cycle -> q = 64'd0 immediately, and q stays 0 for subsequent edges while reset = 1.
REQ-029 Basic load: after reset deasserts, set d = 64'd1 before an edge -> q = 64'd1 after that edge, and q stays 1 while d is unchanged.
REQ-030 Value sequence: drive d = 64'd13, then 64'd1309, each held for several cycles -> q equals each value exactly 1 cycle after it is applied, with no intermediate glitch values.
REQ-031 Mid-cycle async reset: with q = 64'd1309, pulse reset between clock edges -> q = 0 before the next edge, then reloads d on the first edge after release.
REQ-032 Hold check: change d between edges -> q is unchanged until the next rising edge.
REQ-033 Parameter sweep: instantiate WIDTH = 1, 8 and 64 with RESET_VALUE = all-ones, and drive an alternating pattern on d -> q matches d bit-for-bit after 1 cycle, and reset yields all-ones.

Source files
------------

// File: rtl/dff_var_reg.sv
// Parameterised D register built from independent per-bit flip-flop cells.
// Latency: q follows d one rising clk edge later; reset clears q asynchronously.
// Backpressure: none, because the register loads on every edge.

// 2:1 select primitive, shared with the enable-capable register variant.
module dff_mux2 (
    input  logic       sel,
    input  logic [1:0] in,
    output logic       out
);
    assign out = sel ? in[1] : in[0];
endmodule

// Single-bit positive-edge D flip-flop with its own asynchronous reset.
module dff_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    output logic q,
    input  logic d,
    input  logic clk,
    input  logic reset
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

module dff_var_reg #(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             reset
);
    if (WIDTH < 1) begin : g_width_check
        $error("dff_var_reg: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] cell_d;

    // sel is tied high so d always loads; in[0] carries the hold path an enable would pick.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_mux2 u_mux (
            .sel (1'b1),
            .in  ({d[i], q[i]}),
            .out (cell_d[i])
        );

        dff_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .q     (q[i]),
            .d     (cell_d[i]),
            .clk   (clk),
            .reset (reset)
        );
    end
endmodule

// File: tb/tb_dff_var_reg.sv
// Directed plus randomized bench for dff_var_reg at default and swept widths.
module tb_dff_var_reg;
    logic        clk;
    logic        reset;
    logic [63:0] d;
    logic [63:0] q;
    logic [0:0]  d1, q1;
    logic [7:0]  d8, q8;
    logic [63:0] dw, qw;

    int checks = 0;
    int errors = 0;

    // Reference state: what each register should hold according to the load/reset rules.
    logic [63:0] mq, mqw;
    logic [7:0]  mq8;
    logic [0:0]  mq1;

    assign d1 = d[0:0];
    assign d8 = d[7:0];
    assign dw = d;

    dff_var_reg u_dut (
        .q     (q),
        .d     (d),
        .clk   (clk),
        .reset (reset)
    );

    dff_var_reg #(.WIDTH(1), .RESET_VALUE(1'b1)) u_w1 (
        .q     (q1),
        .d     (d1),
        .clk   (clk),
        .reset (reset)
    );

    dff_var_reg #(.WIDTH(8), .RESET_VALUE(8'hFF)) u_w8 (
        .q     (q8),
        .d     (d8),
        .clk   (clk),
        .reset (reset)
    );

    dff_var_reg #(.WIDTH(64), .RESET_VALUE({64{1'b1}})) u_w64 (
        .q     (qw),
        .d     (dw),
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/w64_rv0"}, q, mq);
        chk({tag, "/w1_rv1"}, {63'd0, q1}, {63'd0, mq1});
        chk({tag, "/w8_rv1"}, {56'd0, q8}, {56'd0, mq8});
        chk({tag, "/w64_rv1"}, qw, mqw);
    endtask

    task automatic model_reset();
        mq  = 64'd0;
        mq1 = 1'b1;
        mq8 = 8'hFF;
        mqw = {64{1'b1}};
    endtask

    // One rising edge: the model loads d unless reset holds it.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            mq  = d;
            mq1 = d[0:0];
            mq8 = d[7:0];
            mqw = d;
        end
        #1;
        check_all(tag);
    endtask

    // Apply a new d at the falling edge; q must not move until the next rising edge.
    task automatic apply(input logic [63:0] v, input string tag);
        @(negedge clk);
        d = v;
        #1;
        check_all({tag, "/pre_edge"});
    endtask

    initial begin
        reset = 1'b0;
        d     = 'x;

        // Power-up reset with d unknown.
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("por_immediate");
        tick("por_edge1");
        tick("por_edge2");

        @(negedge clk);
        reset = 1'b0;
        d     = 64'd1;
        #1;
        check_all("release_hold");
        tick("load_one");
        tick("load_one_steady");

        // Value sequence, each held several cycles.
        apply(64'd13, "seq13");
        for (int i = 0; i < 3; i++) tick("seq13");
        apply(64'd1309, "seq1309");
        for (int i = 0; i < 3; i++) tick("seq1309");

        // Mid-cycle async reset pulse, released before the next edge.
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        #1;
        reset = 1'b0;
        #1;
        check_all("async_release_hold");
        tick("reload_after_reset");

        // d changes between edges must not reach q.
        #1;
        d = 64'hDEAD_BEEF_0123_4567;
        #1;
        check_all("hold_mid_cycle");
        tick("hold_then_load");

        // Alternating patterns across all widths.
        apply(64'h5555_5555_5555_5555, "alt55");
        tick("alt55");
        apply(64'hAAAA_AAAA_AAAA_AAAA, "altAA");
        tick("altAA");

        // Randomized data with occasional reset pulses held across an edge.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            d = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                model_reset();
            end else begin
                reset = 1'b0;
            end
            #1;
            check_all("rand_pre_edge");
            tick("rand_edge");
        end

        @(negedge clk);
        reset = 1'b0;
        d     = 64'hFFFF_0000_FFFF_0000;
        tick("final_load");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
